// File: rtl/icache_fetch_responder_pkg.sv
// Shared definitions for the fetch-side I-cache responder: default geometry, bundle bit
// positions, FSM state encoding and the response-bundle packing helper.
package icache_fetch_responder_pkg;

    localparam int DEF_NUM_SETS  = 16;
    localparam int DEF_LINE_BITS = 128;
    localparam int DEF_ADDR_SIZE = 40;

    localparam int WORD_BITS       = 32;
    localparam int WORD_BYTES_LOG2 = 2;

    // Request bundle: {valid, vaddr, inv_icache, inv_buffer, inv_fetch}; valid is the top bit.
    localparam int REQ_FLAG_BITS      = 3;
    localparam int REQ_INV_ICACHE_BIT = 2;
    localparam int REQ_INV_BUFFER_BIT = 1;
    localparam int REQ_INV_FETCH_BIT  = 0;

    // Response bundle: {valid, data[31:0], xcpt}
    localparam int RESP_BITS      = 34;
    localparam int RESP_VALID_BIT = 33;
    localparam int RESP_DATA_LSB  = 1;
    localparam int RESP_XCPT_BIT  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS_REQ,
        ST_MISS_WAIT,
        ST_REPLAY,
        ST_FLUSH
    } fetch_state_e;

    function automatic logic [RESP_BITS-1:0] pack_resp(input logic valid,
                                                       input logic [WORD_BITS-1:0] data,
                                                       input logic xcpt);
        logic [RESP_BITS-1:0] r;
        r = '0;
        r[RESP_VALID_BIT] = valid;
        r[RESP_DATA_LSB +: WORD_BITS] = data;
        r[RESP_XCPT_BIT] = xcpt;
        return r;
    endfunction

endpackage

// File: rtl/icache_fetch_responder_tag_data_array.sv
// icache_tag_data_array: per-set valid/tag/line storage with one async read port,
// one synchronous write port and a per-set valid clear used by the flush walk.
module icache_tag_data_array
    import icache_fetch_responder_pkg::*;
#(
    parameter int NUM_SETS  = DEF_NUM_SETS,
    parameter int TAG_BITS  = 32,
    parameter int LINE_BITS = DEF_LINE_BITS,
    localparam int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_data,
    input  logic                 clr_en,
    input  logic [IDX_W-1:0]     clr_idx
);

    logic [NUM_SETS-1:0]  valid_reg;
    logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS];
    logic [LINE_BITS-1:0] data_mem [NUM_SETS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    // Only the valid bits need reset; stale tag/data behind a cleared valid is harmless.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SETS; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (srst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (clr_en && clr_idx == IDX_W'(gi)) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wr_en && wr_idx == IDX_W'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign rd_valid = valid_reg[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_fetch_responder.sv
// Direct-mapped, identity-translated I-cache answering fetch requests; misses refill one line.
// Optional one-line refill buffer enabled by defining ICACHE_LINE_BUFFER_EN.
module icache_fetch_responder
    import icache_fetch_responder_pkg::*;
#(
    parameter int NUM_SETS  = DEF_NUM_SETS,
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    input  logic [ADDR_SIZE-1:0] req_vaddr_i,
    input  logic                 inv_icache_i,
    input  logic                 inv_buffer_i,
    input  logic                 inv_fetch_i,
    output logic                 resp_valid_o,
    output logic [31:0]          resp_data_o,
    output logic                 resp_xcpt_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic [ADDR_SIZE-1:0] mem_req_addr_o,
    input  logic                 mem_resp_valid_i,
    input  logic [LINE_BITS-1:0] mem_resp_data_i,
    input  logic                 mem_resp_err_i
);

    localparam int WORDS   = LINE_BITS / WORD_BITS;
    localparam int OFF_W   = $clog2(WORDS);
    localparam int BYTE_W  = $clog2(LINE_BITS / 8);
    localparam int IDX_W   = $clog2(NUM_SETS);
    localparam int LADDR_W = ADDR_SIZE - BYTE_W;
    localparam int TAG_W   = LADDR_W - IDX_W;

    logic [ADDR_SIZE+REQ_FLAG_BITS:0] req_bundle;
    logic                 req_valid, inv_icache, inv_buffer, inv_fetch;
    logic [ADDR_SIZE-1:0] req_vaddr;
    logic [LADDR_W-1:0]   req_line;
    logic [OFF_W-1:0]     req_off;

    assign req_bundle = {req_valid_i, req_vaddr_i, inv_icache_i, inv_buffer_i, inv_fetch_i};
    assign req_valid  = req_bundle[ADDR_SIZE+REQ_FLAG_BITS];
    assign req_vaddr  = req_bundle[REQ_FLAG_BITS +: ADDR_SIZE];
    assign inv_icache = req_bundle[REQ_INV_ICACHE_BIT];
    assign inv_buffer = req_bundle[REQ_INV_BUFFER_BIT];
    assign inv_fetch  = req_bundle[REQ_INV_FETCH_BIT];
    assign req_line   = req_vaddr[ADDR_SIZE-1:BYTE_W];
    assign req_off    = req_vaddr[BYTE_W-1:WORD_BYTES_LOG2];

    fetch_state_e          state_reg;
    logic [RESP_BITS-1:0]  resp_bundle_reg;
    logic                  mem_req_valid_reg;
    logic [ADDR_SIZE-1:0]  mem_req_addr_reg;
    logic [LADDR_W-1:0]    miss_line_reg;
    logic [OFF_W-1:0]      miss_off_reg;
    logic                  kill_reg;
    logic                  flush_pending_reg;
    logic [IDX_W-1:0]      flush_idx_reg;

    logic                  arr_valid;
    logic [TAG_W-1:0]      arr_tag;
    logic [LINE_BITS-1:0]  arr_data;
    logic                  arr_hit, hit;
    logic [31:0]           hit_word;
    logic                  refill_done, refill_wr, kill_now, flush_now;
    logic [31:0]           arr_words    [WORDS];
    logic [31:0]           refill_words [WORDS];

    assign refill_done = (state_reg == ST_MISS_WAIT) && mem_resp_valid_i;
    assign refill_wr   = refill_done && !mem_resp_err_i;
    assign kill_now    = kill_reg || inv_fetch;
    assign flush_now   = flush_pending_reg || inv_icache;

    icache_tag_data_array #(
        .NUM_SETS  (NUM_SETS),
        .TAG_BITS  (TAG_W),
        .LINE_BITS (LINE_BITS)
    ) u_array (
        .clk      (clk_i),
        .srst     (rst_i),
        .rd_idx   (req_line[IDX_W-1:0]),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .wr_en    (refill_wr),
        .wr_idx   (miss_line_reg[IDX_W-1:0]),
        .wr_tag   (miss_line_reg[LADDR_W-1:IDX_W]),
        .wr_data  (mem_resp_data_i),
        .clr_en   (state_reg == ST_FLUSH),
        .clr_idx  (flush_idx_reg)
    );

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_words
            assign arr_words[gi]    = arr_data[gi*WORD_BITS +: WORD_BITS];
            assign refill_words[gi] = mem_resp_data_i[gi*WORD_BITS +: WORD_BITS];
        end
    endgenerate

    assign arr_hit = arr_valid && (arr_tag == req_line[LADDR_W-1:IDX_W]);

`ifdef ICACHE_LINE_BUFFER_EN
    logic                 buf_valid_reg;
    logic [LADDR_W-1:0]   buf_line_reg;
    logic [LINE_BITS-1:0] buf_data_reg;
    logic [31:0]          buf_words [WORDS];
    logic                 buf_hit;
    logic                 unused_bits;

    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_buf_words
            assign buf_words[gi] = buf_data_reg[gi*WORD_BITS +: WORD_BITS];
        end
    endgenerate

    // Any invalidate (or an ongoing flush) beats a refill landing in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_valid_reg <= 1'b0;
            buf_line_reg  <= '0;
            buf_data_reg  <= '0;
        end else if (inv_buffer || inv_icache || state_reg == ST_FLUSH) begin
            buf_valid_reg <= 1'b0;
        end else if (refill_wr) begin
            buf_valid_reg <= 1'b1;
            buf_line_reg  <= miss_line_reg;
            buf_data_reg  <= mem_resp_data_i;
        end
    end

    assign buf_hit     = buf_valid_reg && (buf_line_reg == req_line);
    assign hit         = buf_hit || arr_hit;
    assign hit_word    = buf_hit ? buf_words[req_off] : arr_words[req_off];
    assign unused_bits = ^req_vaddr[WORD_BYTES_LOG2-1:0];
`else
    logic unused_bits;
    assign hit         = arr_hit;
    assign hit_word    = arr_words[req_off];
    assign unused_bits = ^{req_vaddr[WORD_BYTES_LOG2-1:0], inv_buffer};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg         <= ST_IDLE;
            resp_bundle_reg   <= '0;
            mem_req_valid_reg <= 1'b0;
            mem_req_addr_reg  <= '0;
            miss_line_reg     <= '0;
            miss_off_reg      <= '0;
            kill_reg          <= 1'b0;
            flush_pending_reg <= 1'b0;
            flush_idx_reg     <= '0;
        end else begin
            resp_bundle_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (inv_icache) begin
                        state_reg     <= ST_FLUSH;
                        flush_idx_reg <= '0;
                    end else if (req_valid && hit) begin
                        resp_bundle_reg <= pack_resp(1'b1, hit_word, 1'b0);
                    end else if (req_valid) begin
                        miss_line_reg     <= req_line;
                        miss_off_reg      <= req_off;
                        mem_req_valid_reg <= 1'b1;
                        mem_req_addr_reg  <= {req_line, BYTE_W'(0)};
                        kill_reg          <= 1'b0;
                        state_reg         <= ST_MISS_REQ;
                    end
                end
                ST_MISS_REQ: begin
                    if (inv_fetch)  kill_reg <= 1'b1;
                    if (inv_icache) flush_pending_reg <= 1'b1;
                    if (mem_req_ready_i) begin
                        mem_req_valid_reg <= 1'b0;
                        state_reg         <= ST_MISS_WAIT;
                    end
                end
                ST_MISS_WAIT: begin
                    if (inv_fetch)  kill_reg <= 1'b1;
                    if (inv_icache) flush_pending_reg <= 1'b1;
                    if (refill_done) begin
                        if (kill_now) begin
                            // Killed refill still lands in the array; only the replay is dropped.
                            kill_reg <= 1'b0;
                            if (flush_now) begin
                                flush_pending_reg <= 1'b0;
                                flush_idx_reg     <= '0;
                                state_reg         <= ST_FLUSH;
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end else begin
                            resp_bundle_reg <= pack_resp(1'b1,
                                mem_resp_err_i ? 32'h0 : refill_words[miss_off_reg],
                                mem_resp_err_i);
                            state_reg <= ST_REPLAY;
                        end
                    end
                end
                ST_REPLAY: begin
                    if (flush_now) begin
                        flush_pending_reg <= 1'b0;
                        flush_idx_reg     <= '0;
                        state_reg         <= ST_FLUSH;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    flush_idx_reg <= flush_idx_reg + IDX_W'(1);
                    if (flush_idx_reg == IDX_W'(NUM_SETS - 1)) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign resp_valid_o    = resp_bundle_reg[RESP_VALID_BIT];
    assign resp_data_o     = resp_bundle_reg[RESP_DATA_LSB +: WORD_BITS];
    assign resp_xcpt_o     = resp_bundle_reg[RESP_XCPT_BIT];
    assign mem_req_valid_o = mem_req_valid_reg;
    assign mem_req_addr_o  = mem_req_addr_reg;

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Scoreboard bench for icache_fetch_responder: a line-level cache model predicts hits,
// refill requests and responses; a memory responder and a response monitor check the DUT.
module tb_icache_fetch_responder;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         req_valid_i = 1'b0;
    logic [39:0]  req_vaddr_i = '0;
    logic         inv_icache_i = 1'b0;
    logic         inv_buffer_i = 1'b0;
    logic         inv_fetch_i = 1'b0;
    logic         resp_valid_o;
    logic [31:0]  resp_data_o;
    logic         resp_xcpt_o;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b0;
    logic [39:0]  mem_req_addr_o;
    logic         mem_resp_valid_i = 1'b0;
    logic [127:0] mem_resp_data_i = '0;
    logic         mem_resp_err_i = 1'b0;

    icache_fetch_responder dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_vaddr_i      (req_vaddr_i),
        .inv_icache_i     (inv_icache_i),
        .inv_buffer_i     (inv_buffer_i),
        .inv_fetch_i      (inv_fetch_i),
        .resp_valid_o     (resp_valid_o),
        .resp_data_o      (resp_data_o),
        .resp_xcpt_o      (resp_xcpt_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_err_i   (mem_resp_err_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int resp_count = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        xcpt;
        logic        chk_lat;
        int          cyc;
    } exp_t;
    typedef struct packed {
        logic [39:0] addr;
        logic        err;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    // Reference model: which line address each set holds, plus the optional refill buffer.
    logic        mv [16];
    logic [35:0] ml [16];
    logic        bv;
    logic [35:0] bl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [39:0] a);
        return (a[31:0] & 32'hFFFF_FFFC) ^ 32'h0000_1013;
    endfunction

    function automatic logic model_hit(input logic [35:0] line);
        logic h;
        h = mv[line[3:0]] && (ml[line[3:0]] == line);
`ifdef ICACHE_LINE_BUFFER_EN
        h = h || (bv && bl == line);
`endif
        return h;
    endfunction

    task automatic model_clear_all();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        bv = 1'b0;
    endtask

    task automatic model_install(input logic [35:0] line);
        mv[line[3:0]] = 1'b1;
        ml[line[3:0]] = line;
        bv = 1'b1;
        bl = line;
    endtask

    // mode: 0 normal, 1 inv_fetch during refill, 2 inv_fetch+inv_icache, 3 inv_icache, 4 reset
    task automatic fetch(input logic [39:0] a, input logic err, input int mode);
        logic [35:0] line;
        exp_t e;
        mem_t m;
        int c0;
        line = a[39:4];
        if (model_hit(line)) begin
            e.data = word_of(a); e.xcpt = 1'b0; e.chk_lat = 1'b1; e.cyc = cyc;
            exp_q.push_back(e);
            req_valid_i = 1'b1; req_vaddr_i = a;
            @(negedge clk);
            req_valid_i = 1'b0;
        end else begin
            m.addr = {line, 4'h0}; m.err = err;
            mem_q.push_back(m);
            if (mode == 0 || mode == 3) begin
                e.data = err ? 32'h0 : word_of(a); e.xcpt = err; e.chk_lat = 1'b0; e.cyc = cyc;
                exp_q.push_back(e);
            end
            c0 = hs_count;
            req_valid_i = 1'b1; req_vaddr_i = a;
            @(negedge clk);
            req_valid_i = 1'b0;
            for (int t = 0; t < 100 && hs_count == c0; t++) @(negedge clk);
            check("refill_request_seen", 64'(hs_count != c0), 64'd1);
            c0 = resp_count;
            if (mode == 1 || mode == 2) inv_fetch_i = 1'b1;
            if (mode == 2 || mode == 3) inv_icache_i = 1'b1;
            if (mode == 4) rst_i = 1'b1;
            @(negedge clk);
            inv_fetch_i = 1'b0; inv_icache_i = 1'b0; rst_i = 1'b0;
            if (mode == 4) begin
                check("post_reset_resp_valid", 64'(resp_valid_o), 64'd0);
                check("post_reset_mem_req", 64'(mem_req_valid_o), 64'd0);
            end
            for (int t = 0; t < 100 && resp_count == c0; t++) @(negedge clk);
            check("refill_data_sent", 64'(resp_count != c0), 64'd1);
            if (mode != 4 && !err) model_install(line);
            if (mode >= 2) model_clear_all();
            repeat ((mode == 2 || mode == 3) ? 20 : 2) @(negedge clk);
        end
    endtask

    // Flush from IDLE: the next request is issued exactly when the 16-set walk has finished.
    task automatic flush_all();
        inv_icache_i = 1'b1;
        @(negedge clk);
        inv_icache_i = 1'b0;
        repeat (16) @(negedge clk);
        model_clear_all();
    endtask

    task automatic drop_buffer();
        inv_buffer_i = 1'b1;
        @(negedge clk);
        inv_buffer_i = 1'b0;
        bv = 1'b0;
    endtask

    // Memory side: checks each refill address against the model, then returns one beat.
    initial begin : mem_responder
        logic [39:0] a;
        logic        e;
        mem_t        me;
        forever begin
            @(negedge clk);
            if (!rst_i && mem_req_valid_o) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                a = mem_req_addr_o;
                check("mem_req_held", 64'(mem_req_valid_o), 64'd1);
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_req: got addr %h expected no request", a);
                    e = 1'b0;
                end else begin
                    me = mem_q.pop_front();
                    check("mem_req_addr", 64'(a), 64'(me.addr));
                    e = me.err;
                end
                mem_req_ready_i = 1'b1;
                @(negedge clk);
                mem_req_ready_i = 1'b0;
                hs_count++;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                mem_resp_valid_i = 1'b1;
                mem_resp_err_i   = e;
                for (int w = 0; w < 4; w++)
                    mem_resp_data_i[w*32 +: 32] = word_of({a[39:4], 2'(w), 2'b00});
                @(negedge clk);
                mem_resp_valid_i = 1'b0;
                mem_resp_err_i   = 1'b0;
                resp_count++;
            end
        end
    end

    initial begin : resp_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_i && resp_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got data %h xcpt %0b expected no response",
                             resp_data_o, resp_xcpt_o);
                end else begin
                    e = exp_q.pop_front();
                    $display("resp cycle %0d data %h xcpt %0b", cyc, resp_data_o, resp_xcpt_o);
                    check("resp_data", 64'(resp_data_o), 64'(e.data));
                    check("resp_xcpt", 64'(resp_xcpt_o), 64'(e.xcpt));
                    if (e.chk_lat) check("hit_latency", 64'(cyc), 64'(e.cyc + 1));
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete within 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] tags [3];
        logic [39:0] a;
        int r, mode;
        tags[0] = 32'h0000_0010; tags[1] = 32'h0000_0011; tags[2] = 32'hA5A5_0010;
        model_clear_all();
        repeat (3) @(negedge clk);
        check("reset_resp_valid", 64'(resp_valid_o), 64'd0);
        check("reset_resp_data", 64'(resp_data_o), 64'd0);
        check("reset_resp_xcpt", 64'(resp_xcpt_o), 64'd0);
        check("reset_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        check("reset_mem_req_addr", 64'(mem_req_addr_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);

        fetch(40'h00_0000_1000, 1'b0, 0);   // cold miss, word0 = 0x13
        fetch(40'h00_0000_1004, 1'b0, 0);   // hit, latency 1
        fetch(40'h00_0000_2000, 1'b1, 0);   // bus error
        fetch(40'h00_0000_2000, 1'b0, 0);   // misses again
        fetch(40'h00_0000_3000, 1'b0, 1);   // killed refill still fills
        fetch(40'h00_0000_3008, 1'b0, 0);   // hit
        flush_all();
        fetch(40'h00_0000_1000, 1'b0, 0);   // miss after flush
        fetch(40'h00_0000_1100, 1'b0, 0);   // alias pair
        fetch(40'h00_0000_1000, 1'b0, 0);
        fetch(40'h00_0000_1100, 1'b0, 0);
        fetch(40'h00_0000_1104, 1'b0, 0);
        fetch(40'h00_0000_4000, 1'b0, 2);   // kill + flush together
        fetch(40'h00_0000_5000, 1'b0, 3);   // flush deferred past refill
        fetch(40'h00_0000_5004, 1'b0, 0);
        fetch(40'h00_0000_6000, 1'b0, 4);   // reset mid-refill
        fetch(40'h00_0000_6000, 1'b0, 0);
        drop_buffer();
        fetch(40'h00_0000_6004, 1'b0, 0);

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            a = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 2'b00};
            mode = $urandom_range(0, 99);
            mode = (mode < 80) ? 0 : (mode < 90) ? 1 : (mode < 94) ? 2 : (mode < 98) ? 3 : 4;
            if (r < 6)       flush_all();
            else if (r < 12) drop_buffer();
            else             fetch(a, 1'($urandom_range(0, 9) == 0), mode);
        end

        repeat (10) @(negedge clk);
        check("resp_queue_drained", 64'(exp_q.size()), 64'd0);
        check("mem_queue_drained", 64'(mem_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
